// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect request bundle between the pipeline stages and pipe_ctrl.
// master: pipeline side raising requests; slave: the stall/flush controller.
interface pipe_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    logic            id_stall_req;
    logic            ex_multi_start;
    logic            mem_req;
    logic            mem_ack;
    logic            flush_req;
    logic [PC_W-1:0] flush_pc;
    logic [4:0]      stall;
    logic            flush;
    logic [PC_W-1:0] new_pc;
    logic            ex_done;
    logic            busy;

    modport master (
        output id_stall_req, ex_multi_start, mem_req, mem_ack, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_done, busy
    );

    modport slave (
        input  id_stall_req, ex_multi_start, mem_req, mem_ack, flush_req, flush_pc,
        output stall, flush, new_pc, ex_done, busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: turns ID/EX/MEM hazard and redirect requests into a
// contiguous per-register stall vector and a one-cycle registered flush with target PC.
module pipe_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned PC_W       = 32
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StRun, StExBusy, StMemWait, StFlush} state_t;

    // Stall patterns; bit 0 is the PC register.
    localparam logic [4:0] StallNone  = 5'b00000;
    localparam logic [4:0] StallId    = 5'b00011;
    localparam logic [4:0] StallEx    = 5'b00111;
    localparam logic [4:0] StallMem   = 5'b01111;
    localparam logic [4:0] StallAll   = 5'b11111;
    localparam logic [3:0] CntLoad    = 4'(MUL_CYCLES - 2);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [4:0]      stall_c;
    logic            done_c;

    // Next-state, counter, pending-redirect capture and same-cycle stall response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pc_d    = pc_q;
        stall_c = StallNone;
        done_c  = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.flush_req) begin
                    stall_c = StallAll;
                    pc_d    = bus.flush_pc;
                    state_d = StFlush;
                end else if (bus.mem_req && !bus.mem_ack) begin
                    stall_c = StallMem;
                    state_d = StMemWait;
                end else if (bus.ex_multi_start) begin
                    stall_c = StallEx;
                    cnt_d   = CntLoad;
                    state_d = StExBusy;
                end else if (bus.id_stall_req) begin
                    stall_c = StallId;
                end
            end
            StExBusy: begin
                if (bus.flush_req) begin
                    // Redirect kills the in-flight op; its result is never reported.
                    stall_c = StallAll;
                    pc_d    = bus.flush_pc;
                    state_d = StFlush;
                end else if (cnt_q == 4'd0) begin
                    done_c  = 1'b1;
                    stall_c = bus.id_stall_req ? StallId : StallNone;
                    state_d = StRun;
                end else begin
                    stall_c = StallEx;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            StMemWait: begin
                if (bus.mem_ack) begin
                    if (pend_q || bus.flush_req) begin
                        stall_c = StallAll;
                        pend_d  = 1'b0;
                        state_d = StFlush;
                        if (bus.flush_req) begin
                            pc_d = bus.flush_pc;
                        end
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    stall_c = StallMem;
                    // Redirect must wait for the access to retire; keep the newest target.
                    if (bus.flush_req) begin
                        pend_d = 1'b1;
                        pc_d   = bus.flush_pc;
                    end
                end
            end
            StFlush: begin
                if (bus.flush_req) begin
                    pc_d    = bus.flush_pc;
                    state_d = StFlush;
                end else begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs are forced quiet while reset is held, even before the reset edge lands.
    always_comb begin
        bus.stall   = rst ? StallNone : stall_c;
        bus.ex_done = !rst && done_c;
        bus.busy    = !rst && (state_q != StRun);
        bus.flush   = !rst && (state_q == StFlush);
        bus.new_pc  = rst ? '0 : pc_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MUL_CYCLES=4. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    localparam int unsigned PC_W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.PC_W(PC_W)) bus ();

    pipe_ctrl #(
        .MUL_CYCLES(4),
        .PC_W      (PC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        bus.id_stall_req   = 1'b0;
        bus.ex_multi_start = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_ack        = 1'b0;
        bus.flush_req      = 1'b0;
        bus.flush_pc       = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.stall !== 5'b0) begin
            $display("FAIL reset_stall: got %b want %b", bus.stall, 5'b0); errors++; end
        checks++; if (bus.busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", bus.busy); errors++; end
        checks++; if (bus.flush !== 1'b0 || bus.ex_done !== 1'b0) begin
            $display("FAIL reset_flush_done: got flush=%b done=%b want 0/0",
                     bus.flush, bus.ex_done); errors++; end
        checks++; if (bus.new_pc !== 32'h0) begin
            $display("FAIL reset_new_pc: got %h want 0", bus.new_pc); errors++; end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.stall !== 5'b0) begin
            $display("FAIL reset_release: got busy=%b stall=%b want 0/00000",
                     bus.busy, bus.stall); errors++; end
        next_cycle();
    endtask

    task automatic test_load_use();
        bus.id_stall_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.stall !== 5'b00011) begin
            $display("FAIL load_use_stall: got %b want 00011", bus.stall); errors++; end
        checks++; if (bus.busy !== 1'b0) begin
            $display("FAIL load_use_busy: got %b want 0", bus.busy); errors++; end
        next_cycle();
        bus.id_stall_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.stall !== 5'b0) begin
            $display("FAIL load_use_release: got %b want 00000", bus.stall); errors++; end
        next_cycle();
    endtask

    task automatic test_multi_cycle(input string tag);
        logic [4:0] es[4] = '{5'b00111, 5'b00111, 5'b00111, 5'b00000};
        logic       ed[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       eb[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.ex_multi_start = (i == 0);
            @(negedge clk);
            checks++; if (bus.stall !== es[i]) begin
                $display("FAIL %s_stall c%0d: got %b want %b", tag, i, bus.stall, es[i]);
                errors++; end
            checks++; if (bus.ex_done !== ed[i]) begin
                $display("FAIL %s_done c%0d: got %b want %b", tag, i, bus.ex_done, ed[i]);
                errors++; end
            checks++; if (bus.busy !== eb[i]) begin
                $display("FAIL %s_busy c%0d: got %b want %b", tag, i, bus.busy, eb[i]);
                errors++; end
            next_cycle();
        end
        bus.ex_multi_start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.ex_done !== 1'b0) begin
            $display("FAIL %s_after: got busy=%b done=%b want 0/0", tag, bus.busy, bus.ex_done);
            errors++; end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        logic [4:0] es[4] = '{5'b01111, 5'b01111, 5'b01111, 5'b00000};
        logic       eb[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.mem_req = 1'b1;
            bus.mem_ack = (i == 3);
            @(negedge clk);
            checks++; if (bus.stall !== es[i] || bus.busy !== eb[i]) begin
                $display("FAIL mem_wait c%0d: got stall=%b busy=%b want %b/%b",
                         i, bus.stall, bus.busy, es[i], eb[i]); errors++; end
            next_cycle();
        end
        // Access acked in its first cycle: no stall, no state change.
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (bus.stall !== 5'b0 || bus.busy !== 1'b0) begin
            $display("FAIL mem_fast_ack: got stall=%b busy=%b want 00000/0",
                     bus.stall, bus.busy); errors++; end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin
            $display("FAIL mem_fast_ack_next: got busy=%b want 0", bus.busy); errors++; end
        next_cycle();
    endtask

    task automatic test_redirect();
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h0000_0040;
        @(negedge clk);
        checks++; if (bus.stall !== 5'b11111 || bus.flush !== 1'b0) begin
            $display("FAIL redirect_req: got stall=%b flush=%b want 11111/0",
                     bus.stall, bus.flush); errors++; end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h40 || bus.stall !== 5'b0) begin
            $display("FAIL redirect_flush: got flush=%b pc=%h stall=%b want 1/00000040/00000",
                     bus.flush, bus.new_pc, bus.stall); errors++; end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL redirect_after: got flush=%b busy=%b want 0/0", bus.flush, bus.busy);
            errors++; end
        next_cycle();
    endtask

    task automatic test_deferred_flush();
        // c0 enter MEM_WAIT, c1 redirect arrives, c2 still waiting, c3 ack, c4 flush.
        logic       fr[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       ak[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] es[4] = '{5'b01111, 5'b01111, 5'b01111, 5'b11111};
        for (int i = 0; i < 4; i++) begin
            bus.mem_req   = 1'b1;
            bus.mem_ack   = ak[i];
            bus.flush_req = fr[i];
            bus.flush_pc  = fr[i] ? 32'h80 : 32'h0;
            @(negedge clk);
            checks++; if (bus.stall !== es[i] || bus.flush !== 1'b0) begin
                $display("FAIL deferred c%0d: got stall=%b flush=%b want %b/0",
                         i, bus.stall, bus.flush, es[i]); errors++; end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h80) begin
            $display("FAIL deferred_flush: got flush=%b pc=%h want 1/00000080",
                     bus.flush, bus.new_pc); errors++; end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL deferred_after: got flush=%b busy=%b want 0/0", bus.flush, bus.busy);
            errors++; end
        next_cycle();
    endtask

    task automatic test_ex_abort();
        bus.ex_multi_start = 1'b1;
        next_cycle();
        bus.ex_multi_start = 1'b0;
        bus.flush_req      = 1'b1;
        bus.flush_pc       = 32'h0000_00c0;
        @(negedge clk);
        checks++; if (bus.stall !== 5'b11111 || bus.ex_done !== 1'b0) begin
            $display("FAIL ex_abort_req: got stall=%b done=%b want 11111/0",
                     bus.stall, bus.ex_done); errors++; end
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.ex_done !== 1'b0 || bus.flush !== (i == 0)) begin
                $display("FAIL ex_abort c%0d: got done=%b flush=%b want 0/%b",
                         i, bus.ex_done, bus.flush, (i == 0)); errors++; end
            if (i == 0) begin
                checks++; if (bus.new_pc !== 32'hc0) begin
                    $display("FAIL ex_abort_pc: got %h want 000000c0", bus.new_pc); errors++; end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        bus.ex_multi_start = 1'b1;
        next_cycle();
        bus.ex_multi_start = 1'b0;
        rst = 1'b1; // cnt is 2 here
        @(negedge clk);
        checks++; if (bus.stall !== 5'b0 || bus.busy !== 1'b0 || bus.ex_done !== 1'b0) begin
            $display("FAIL reset_mid_hold: got stall=%b busy=%b done=%b want 00000/0/0",
                     bus.stall, bus.busy, bus.ex_done); errors++; end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.stall !== 5'b0 || bus.busy !== 1'b0 || bus.ex_done !== 1'b0) begin
                $display("FAIL reset_mid c%0d: got stall=%b busy=%b done=%b want 00000/0/0",
                         i, bus.stall, bus.busy, bus.ex_done); errors++; end
            next_cycle();
        end
        test_multi_cycle("multi_after_rst");
    endtask

    task automatic test_back_to_back();
        // Priority in RUN: memory wait beats multi-cycle start and load-use.
        bus.mem_req        = 1'b1;
        bus.ex_multi_start = 1'b1;
        bus.id_stall_req   = 1'b1;
        @(negedge clk);
        checks++; if (bus.stall !== 5'b01111) begin
            $display("FAIL priority_mem: got %b want 01111", bus.stall); errors++; end
        next_cycle();
        idle_inputs();
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b1;
        next_cycle();
        idle_inputs();
        // Redirect arriving during FLUSH re-enters FLUSH with the newer target.
        bus.flush_req = 1'b1;
        bus.flush_pc  = 32'h100;
        next_cycle();
        bus.flush_pc  = 32'h104;
        @(negedge clk);
        checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h100 || bus.stall !== 5'b0) begin
            $display("FAIL b2b_first: got flush=%b pc=%h stall=%b want 1/00000100/00000",
                     bus.flush, bus.new_pc, bus.stall); errors++; end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h104) begin
            $display("FAIL b2b_second: got flush=%b pc=%h want 1/00000104",
                     bus.flush, bus.new_pc); errors++; end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.flush !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL b2b_after: got flush=%b busy=%b want 0/0", bus.flush, bus.busy);
            errors++; end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_load_use();
        test_multi_cycle("multi");
        test_mem_wait();
        test_redirect();
        test_deferred_flush();
        test_ex_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
